led_pattern_sequencer: RTL and testbench

//  Drives the 8-LED bar on the board from one clock.
//  - Internal prescaler produces the step tick.
//  - A small state machine selects and steps one of five LED patterns.
//  - Mode requests from the switch/button logic use a valid/ack handshake.
//  - Replaces free-running ad-hoc shifters; all LED animation goes through this block.

---
 rtl/led_pattern_sequencer.sv | 133 +++++++++++++
 tb/tb_led_pattern_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// Drives the LED bar with one of five step patterns, paced by an internal prescaler.
// Mode changes arrive by a valid/ack handshake and take effect on the next step tick.
module led_pattern_sequencer #(
   parameter int WIDTH    = 8,
   parameter int DIV_BITS = 19
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic [2:0]       iMODE,
   input  logic             iMODE_VLD,
   input  logic [1:0]       iSPEED,
   input  logic             iPAUSE,
   output logic [WIDTH-1:0] oLED,
   output logic             oSTEP,
   output logic [2:0]       oMODE,
   output logic             oMODE_ACK,
   output logic             oMODE_ERR
);

   typedef enum logic [2:0] {
      BOUNCE = 3'd0,
      ROT_L  = 3'd1,
      ROT_R  = 3'd2,
      BLINK  = 3'd3,
      FILL   = 3'd4
   } patternMode_t;

   localparam logic [WIDTH-1:0] LED_LSB = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] LED_MSB = {1'b1, {(WIDTH-1){1'b0}}};

   patternMode_t          r_mode;
   patternMode_t          r_pend;
   logic                  r_pendVld;
   logic [WIDTH-1:0]      r_led;
   logic                  r_dirLeft;
   logic [DIV_BITS-1:0]   r_count;
   logic                  r_step;
   logic                  r_ack;
   logic                  r_err;

   logic [DIV_BITS-1:0]   w_terminal;
   logic                  w_tick;
   logic                  w_reqValid;
   patternMode_t          w_nextMode;
   logic [WIDTH-1:0]      w_nextLed;
   logic                  w_nextDirLeft;

   // Terminal count is compared with >= so a speed-up mid-count ticks immediately.
   assign w_terminal = {DIV_BITS{1'b1}} >> iSPEED;
   assign w_tick     = !iPAUSE && (r_count >= w_terminal);
   assign w_reqValid = (iMODE <= 3'd4);

   always_comb begin
      w_nextMode    = r_mode;
      w_nextLed     = r_led;
      w_nextDirLeft = r_dirLeft;
      if (w_tick) begin
         if (r_pendVld) begin
            w_nextMode    = r_pend;
            w_nextDirLeft = 1'b1;
            case (r_pend)
               ROT_R:   w_nextLed = LED_MSB;
               BLINK:   w_nextLed = {WIDTH{1'b1}};
               default: w_nextLed = LED_LSB;
            endcase
         end else begin
            case (r_mode)
               BOUNCE: begin
                  // Reverse at an end so each end lamp is shown for exactly one step.
                  if (r_dirLeft) begin
                     if (r_led[WIDTH-1]) begin
                        w_nextLed     = r_led >> 1;
                        w_nextDirLeft = 1'b0;
                     end else begin
                        w_nextLed = r_led << 1;
                     end
                  end else begin
                     if (r_led[0]) begin
                        w_nextLed     = r_led << 1;
                        w_nextDirLeft = 1'b1;
                     end else begin
                        w_nextLed = r_led >> 1;
                     end
                  end
               end
               ROT_L:   w_nextLed = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
               ROT_R:   w_nextLed = {r_led[0], r_led[WIDTH-1:1]};
               BLINK:   w_nextLed = ~r_led;
               FILL:    w_nextLed = (&r_led) ? '0 : {r_led[WIDTH-2:0], 1'b1};
               default: w_nextLed = LED_LSB;
            endcase
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         r_mode    <= BOUNCE;
         r_pend    <= BOUNCE;
         r_pendVld <= 1'b0;
         r_led     <= LED_LSB;
         r_dirLeft <= 1'b1;
         r_count   <= '0;
         r_step    <= 1'b0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_mode    <= w_nextMode;
         r_led     <= w_nextLed;
         r_dirLeft <= w_nextDirLeft;
         r_step    <= w_tick;
         r_ack     <= w_tick & r_pendVld;
         r_err     <= iMODE_VLD & ~w_reqValid;
         if (!iPAUSE) begin
            r_count <= w_tick ? '0 : r_count + 1'b1;
         end
         // A request in the tick cycle itself survives for the following tick.
         if (iMODE_VLD && w_reqValid) begin
            r_pend    <= patternMode_t'(iMODE);
            r_pendVld <= 1'b1;
         end else if (w_tick) begin
            r_pendVld <= 1'b0;
         end
      end
   end

   assign oLED      = r_led;
   assign oSTEP     = r_step;
   assign oMODE     = r_mode;
   assign oMODE_ACK = r_ack;
   assign oMODE_ERR = r_err;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: directed scenarios then random traffic,
// compared every cycle against a pattern-index reference model.
module tb_led_pattern_sequencer;

   logic       clk;
   logic       rstN;
   logic [2:0] modeIn;
   logic       modeVld;
   logic [1:0] speed;
   logic       pause;
   logic [7:0] led;
   logic       step;
   logic [2:0] modeOut;
   logic       modeAck;
   logic       modeErr;

   int testCount = 0;
   int failCount = 0;
   int stepSeen  = 0;
   int ackSeen   = 0;

   // Reference model: pattern is described by an index into its cycle, not by shifts.
   int mCount   = 0;
   int mMode    = 0;
   int mIdx     = 0;
   int mPend    = 0;
   bit mPendVld = 0;
   bit mStep    = 0;
   bit mAck     = 0;
   bit mErr     = 0;

   led_pattern_sequencer #(.WIDTH(8), .DIV_BITS(4)) dut (
      .iCLK      (clk),
      .iRST_N    (rstN),
      .iMODE     (modeIn),
      .iMODE_VLD (modeVld),
      .iSPEED    (speed),
      .iPAUSE    (pause),
      .oLED      (led),
      .oSTEP     (step),
      .oMODE     (modeOut),
      .oMODE_ACK (modeAck),
      .oMODE_ERR (modeErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int seqLen(input int m);
      case (m)
         0:       return 14;
         1:       return 8;
         2:       return 8;
         3:       return 2;
         default: return 9;
      endcase
   endfunction

   function automatic logic [7:0] ledFor(input int m, input int idx);
      int p;
      case (m)
         0: begin
            p = (idx < 8) ? idx : 14 - idx;
            return 8'(1 << p);
         end
         1:       return 8'(1 << idx);
         2:       return 8'(128 >> idx);
         3:       return (idx == 0) ? 8'hFF : 8'h00;
         default: return 8'((1 << ((idx + 1) % 9)) - 1);
      endcase
   endfunction

   task automatic modelStep();
      int period;
      bit tick;
      if (!rstN) begin
         mCount = 0; mMode = 0; mIdx = 0; mPend = 0; mPendVld = 0;
         mStep = 0; mAck = 0; mErr = 0;
      end else begin
         period = 16 >> speed;
         tick   = !pause && (mCount >= period - 1);
         mStep  = tick;
         mAck   = tick && mPendVld;
         mErr   = modeVld && (modeIn > 3'd4);
         if (!pause) mCount = tick ? 0 : mCount + 1;
         if (tick) begin
            if (mPendVld) begin
               mMode    = mPend;
               mIdx     = 0;
               mPendVld = 0;
            end else begin
               mIdx = (mIdx + 1) % seqLen(mMode);
            end
         end
         if (modeVld && modeIn <= 3'd4) begin
            mPend    = int'(modeIn);
            mPendVld = 1;
         end
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit r, input logic [2:0] m, input bit v,
                                input logic [1:0] s, input bit p);
      rstN    = r;
      modeIn  = m;
      modeVld = v;
      speed   = s;
      pause   = p;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("led",  32'(led),     32'(ledFor(mMode, mIdx)));
      checkOutput("step", 32'(step),    32'(mStep));
      checkOutput("mode", 32'(modeOut), 32'(mMode));
      checkOutput("ack",  32'(modeAck), 32'(mAck));
      checkOutput("err",  32'(modeErr), 32'(mErr));
      if (step) stepSeen++;
      if (modeAck) ackSeen++;
   endtask

   initial begin
      rstN = 1'b0; modeIn = '0; modeVld = 1'b0; speed = '0; pause = 1'b0;

      // Reset and free-running bounce at the slowest rate.
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("resetLed", 32'(led), 32'h01);
      stepSeen = 0;
      for (int i = 0; i < 300; i++) applyStimulus(1, 0, 0, 0, 0);
      checkOutput("stepCount", 32'(stepSeen), 32'd18);

      // Speed-up mid-count ticks on the very next edge.
      applyStimulus(0, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 3, 0);
      checkOutput("fastTick", 32'(step), 32'd1);
      for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0, 3, 0);

      // Two requests before one tick: last wins, single ack.
      applyStimulus(0, 0, 0, 0, 0);
      ackSeen = 0;
      applyStimulus(1, 2, 1, 0, 0);
      applyStimulus(1, 4, 1, 0, 0);
      for (int i = 0; i < 40; i++) applyStimulus(1, 0, 0, 0, 0);
      checkOutput("singleAck", 32'(ackSeen), 32'd1);
      checkOutput("fillMode", 32'(modeOut), 32'd4);

      // Invalid code.
      ackSeen = 0;
      applyStimulus(1, 6, 1, 0, 0);
      checkOutput("errPulse", 32'(modeErr), 32'd1);
      for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 0, 0);
      checkOutput("noAckOnErr", 32'(ackSeen), 32'd0);

      // Pause with a request pending.
      ackSeen = 0;
      applyStimulus(1, 1, 1, 0, 1);
      for (int i = 0; i < 50; i++) applyStimulus(1, 0, 0, 0, 1);
      checkOutput("noAckPaused", 32'(ackSeen), 32'd0);
      for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 0, 0);
      checkOutput("ackAfterPause", 32'(ackSeen), 32'd1);

      // Reset during the blink off phase.
      applyStimulus(1, 3, 1, 2, 0);
      for (int i = 0; i < 100 && !(mMode == 3 && ledFor(mMode, mIdx) == 8'h00); i++)
         applyStimulus(1, 0, 0, 2, 0);
      checkOutput("blinkOffReached", 32'(led), 32'h00);
      applyStimulus(0, 0, 0, 2, 0);
      checkOutput("rstLed", 32'(led), 32'h01);
      checkOutput("rstMode", 32'(modeOut), 32'd0);
      checkOutput("rstPulses", {29'd0, step, modeAck, modeErr}, 32'd0);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         if (i % 64 == 0) speed = 2'($urandom_range(0, 3));
         applyStimulus($urandom_range(0, 199) != 0,
                       3'($urandom_range(0, 7)),
                       $urandom_range(0, 9) == 0,
                       speed,
                       $urandom_range(0, 19) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
